tx_bit_encoder: RTL

TX_BIT_ENCODER -- requirements
Module: tx_bit_encoder

---
 rtl/usb_tx_pkg.sv | 39 +++
 rtl/tx_bit_encoder_if.sv | 22 ++
 rtl/stuff_counter.sv | 29 ++
 rtl/tx_bit_encoder.sv | 83 ++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared USB TX definitions: FSM phase codes, encoder states and line symbols.
// Imported by the TX FSM and by the bit encoder.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_PID    = 3'd1,
        PH_SYNC   = 3'd2,
        PH_DATA   = 3'd3,
        PH_CRC_LO = 3'd4,
        PH_CRC_HI = 3'd5,
        PH_EOP1   = 3'd6,
        PH_EOP2   = 3'd7
    } tx_phase_e;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_XMIT,
        ENC_STUFF,
        ENC_EOP
    } enc_state_e;

    // Line symbols as {dplus, dminus}; {1,1} is never driven.
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    // Number of consecutive ones that forces a stuffed zero.
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    function automatic logic [1:0] sym_of(input logic level);
        return level ? SYM_J : SYM_K;
    endfunction

    function automatic logic is_eop_phase(input tx_phase_e ph);
        return (ph == PH_EOP1) || (ph == PH_EOP2);
    endfunction

endpackage

// File: rtl/tx_bit_encoder_if.sv
// Bit-level link between the TX FSM / shift register and the line encoder.
interface tx_bit_encoder_if;

    logic       shift_strobe;
    logic       serial_in;
    logic [2:0] state_val;
    logic       dplus_out;
    logic       dminus_out;
    logic       stuff_stall;
    logic       tx_active;

    modport master (
        output shift_strobe, serial_in, state_val,
        input  dplus_out, dminus_out, stuff_stall, tx_active
    );

    modport slave (
        input  shift_strobe, serial_in, state_val,
        output dplus_out, dminus_out, stuff_stall, tx_active
    );

endinterface

// File: rtl/stuff_counter.sv
// Consecutive-ones counter for bit stuffing; flags the cycle the count reaches six.
module stuff_counter
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic hit_limit
);

    logic [2:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 3'd1;
        end
    end

    // High when the increment being applied now takes the count to the limit.
    assign hit_limit = en && !clr && (count_q == (STUFF_LIMIT - 3'd1));

endmodule

// File: rtl/tx_bit_encoder.sv
// USB TX line encoder: NRZI, bit stuffing and EOP/idle line drive, one step per shift_strobe.
module tx_bit_encoder
    import usb_tx_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    tx_bit_encoder_if.slave  bus
);

    enc_state_e state_q;
    logic [1:0] line_q;
    logic       stall_q;
    logic       active_q;

    tx_phase_e  phase;
    logic       ph_idle;
    logic       ph_eop;
    logic       encode_bit;
    logic       base_level;
    logic [1:0] nrzi_sym;
    logic       cnt_en;
    logic       cnt_clr;
    logic       hit_six;

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        phase      = tx_phase_e'(bus.state_val);
        ph_idle    = (phase == PH_IDLE);
        ph_eop     = is_eop_phase(phase);
        encode_bit = !ph_idle && !ph_eop && (state_q != ENC_STUFF);
        // A new packet from IDLE or EOP always starts relative to J.
        base_level = (state_q == ENC_XMIT) ? line_q[1] : 1'b1;
        nrzi_sym   = sym_of(bus.serial_in ? base_level : ~base_level);
        cnt_en     = bus.shift_strobe && encode_bit && bus.serial_in;
        cnt_clr    = bus.shift_strobe && !(encode_bit && bus.serial_in);
    end

    stuff_counter u_stuff_counter (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (cnt_en),
        .clr       (cnt_clr),
        .hit_limit (hit_six)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ENC_IDLE;
            line_q   <= SYM_J;
            stall_q  <= 1'b0;
            active_q <= 1'b0;
        end else if (bus.shift_strobe) begin
            if (ph_idle) begin
                state_q  <= ENC_IDLE;
                line_q   <= SYM_J;
                stall_q  <= 1'b0;
                active_q <= 1'b0;
            end else if (ph_eop) begin
                // EOP is ignored while idle; elsewhere it drops any pending stuff bit.
                if (state_q != ENC_IDLE) begin
                    state_q <= ENC_EOP;
                    line_q  <= SYM_SE0;
                    stall_q <= 1'b0;
                end
            end else if (state_q == ENC_STUFF) begin
                state_q <= ENC_XMIT;
                line_q  <= sym_of(~line_q[1]);
                stall_q <= 1'b0;
            end else begin
                state_q  <= hit_six ? ENC_STUFF : ENC_XMIT;
                line_q   <= nrzi_sym;
                stall_q  <= hit_six;
                active_q <= 1'b1;
            end
        end
    end

    assign bus.dplus_out   = line_q[1];
    assign bus.dminus_out  = line_q[0];
    assign bus.stuff_stall = stall_q;
    assign bus.tx_active   = active_q;

endmodule
